// File: rtl/qspi_pkg.sv
// Shared constants and helpers for the QSPI transfer engine: FSM state codes,
// line-mode codes and the phase-sequencing rule.
package qspi_pkg;

    // States are ordered so that next_phase can compare codes numerically
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INSTR = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_GAP   = 3'd6;

    localparam logic [1:0] MODE_SKIP   = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_QUAD   = 2'd2;

    localparam int unsigned MAX_BYTES      = 32;
    localparam int unsigned MAX_ADDR_BYTES = 4;

    function automatic logic mode_run(input logic [1:0] mode);
        return (mode == MODE_SINGLE) || (mode == MODE_QUAD);
    endfunction

    // First active phase strictly after cur; DONE when none remain
    function automatic logic [2:0] next_phase(input logic [2:0] cur,
                                              input logic run_instr,
                                              input logic run_addr,
                                              input logic run_dummy,
                                              input logic run_data);
        logic [2:0] nxt;
        nxt = ST_DONE;
        if (run_data  && cur < ST_DATA)  nxt = ST_DATA;
        if (run_dummy && cur < ST_DUMMY) nxt = ST_DUMMY;
        if (run_addr  && cur < ST_ADDR)  nxt = ST_ADDR;
        if (run_instr && cur < ST_INSTR) nxt = ST_INSTR;
        return nxt;
    endfunction

endpackage

// File: rtl/qspi_sclk_gen.sv
// SPI mode-0 bit-slot generator: SCLK low for CLK_DIV cycles then high for
// CLK_DIV cycles, with a strobe on the last cycle of each slot.
module qspi_sclk_gen
#(
    parameter int unsigned CLK_DIV = 2
)
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_shift,
    output logic o_sample
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_half_cnt;
    logic             r_sclk;
    logic             w_half_end;

    assign w_half_end = (r_half_cnt == HALF_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_half_cnt <= '0;
            r_sclk     <= 1'b0;
        end else if (!i_en) begin
            r_half_cnt <= '0;
            r_sclk     <= 1'b0;
        end else if (w_half_end) begin
            r_half_cnt <= '0;
            r_sclk     <= ~r_sclk;
        end else begin
            r_half_cnt <= r_half_cnt + CNT_W'(1);
        end
    end

    // Input is captured and the next bit is launched on the same edge that
    // drops SCLK, so both strobes mark the final cycle of the high half.
    assign o_sample = i_en & r_sclk & w_half_end;
    assign o_shift  = i_en & r_sclk & w_half_end;
    assign o_sclk   = r_sclk;

endmodule

// File: rtl/qspi_xfer_engine.sv
// QSPI master serial engine: sequences instruction/address/dummy/data phases
// of one decoded command per start pulse and collects read data into a 256-bit buffer.
module qspi_xfer_engine
    import qspi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
)
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [7:0]   instr_i,
    input  logic [1:0]   instr_mode_i,
    input  logic [1:0]   addr_mode_i,
    input  logic [2:0]   addr_bytes_i,
    input  logic [31:0]  addr_i,
    input  logic [4:0]   dummy_i,
    input  logic [1:0]   data_mode_i,
    input  logic         data_dir_i,
    input  logic [5:0]   data_bytes_i,
    input  logic [255:0] wdata_i,
    output logic [255:0] rdata_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         sclk_o,
    output logic         ss_n_o,
    output logic [3:0]   io_o,
    output logic [3:0]   io_oe_o,
    input  logic [3:0]   io_i
);

    localparam int unsigned WAIT_W = $clog2(2 * CLK_DIV + 1);
    localparam logic [WAIT_W-1:0] DONE_LAST = WAIT_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(2 * CLK_DIV - 1);

    logic [2:0]        r_state;
    logic [7:0]        r_instr;
    logic [1:0]        r_imode, r_amode, r_dmode;
    logic [2:0]        r_abytes;
    logic [31:0]       r_addr;
    logic [4:0]        r_dummy;
    logic              r_dir;
    logic [5:0]        r_dbytes;
    logic [255:0]      r_wdata;
    logic [255:0]      r_rdata;
    logic [31:0]       r_shift;
    logic [7:0]        r_rx;
    logic [2:0]        r_bit_cnt;
    logic [5:0]        r_byte_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_done;

    logic        w_idle, w_sclk_en, w_shift, w_sample;
    logic [7:0]  w_instr, w_wbyte0;
    logic [1:0]  w_imode, w_amode, w_dmode;
    logic [2:0]  w_abytes;
    logic [31:0] w_addr;
    logic [4:0]  w_dummy;
    logic [5:0]  w_dbytes;
    logic        w_run_i, w_run_a, w_run_d, w_run_t;
    logic [2:0]  w_enter;
    logic [31:0] w_load_shift;
    logic [1:0]  w_cur_mode;
    logic [5:0]  w_cur_units;
    logic        w_quad, w_last_bit, w_phase_last, w_reading, w_dummy_quad;
    logic [7:0]  w_rx_next;
    logic [4:0]  w_nxt_byte;

    // In IDLE the phase decision looks at the live inputs so the first phase
    // can be entered on the accepting edge; afterwards it uses latched copies.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_instr  = w_idle ? instr_i      : r_instr;
    assign w_imode  = w_idle ? instr_mode_i : r_imode;
    assign w_amode  = w_idle ? addr_mode_i  : r_amode;
    assign w_abytes = w_idle ? ((addr_bytes_i > 3'(MAX_ADDR_BYTES)) ? 3'(MAX_ADDR_BYTES) : addr_bytes_i)
                             : r_abytes;
    assign w_addr   = w_idle ? addr_i       : r_addr;
    assign w_dummy  = w_idle ? dummy_i      : r_dummy;
    assign w_dmode  = w_idle ? data_mode_i  : r_dmode;
    assign w_dbytes = w_idle ? ((data_bytes_i > 6'(MAX_BYTES)) ? 6'(MAX_BYTES) : data_bytes_i)
                             : r_dbytes;
    assign w_wbyte0 = w_idle ? wdata_i[7:0] : r_wdata[7:0];

    assign w_run_i = mode_run(w_imode);
    assign w_run_a = mode_run(w_amode) && (w_abytes != 3'd0);
    assign w_run_d = (w_dummy != 5'd0);
    assign w_run_t = mode_run(w_dmode) && (w_dbytes != 6'd0);
    assign w_enter = next_phase(r_state, w_run_i, w_run_a, w_run_d, w_run_t);

    always_comb begin
        w_load_shift = '0;
        case (w_enter)
            ST_INSTR: w_load_shift = {w_instr, 24'h0};
            ST_ADDR:  w_load_shift = w_addr << (6'd32 - {w_abytes, 3'b000});
            ST_DATA:  w_load_shift = {w_wbyte0, 24'h0};
            default:  w_load_shift = '0;
        endcase
    end

    always_comb begin
        w_cur_mode  = MODE_SKIP;
        w_cur_units = 6'd1;
        case (r_state)
            ST_INSTR: w_cur_mode = r_imode;
            ST_ADDR:  begin w_cur_mode = r_amode; w_cur_units = {3'b000, r_abytes}; end
            ST_DUMMY: w_cur_units = {1'b0, r_dummy};
            ST_DATA:  begin w_cur_mode = r_dmode; w_cur_units = r_dbytes; end
            default:  w_cur_units = 6'd1;
        endcase
    end

    assign w_quad       = (w_cur_mode == MODE_QUAD);
    assign w_last_bit   = w_quad ? (r_bit_cnt == 3'd1) : (r_bit_cnt == 3'd7);
    assign w_phase_last = (r_byte_cnt == w_cur_units - 6'd1) &&
                          ((r_state == ST_DUMMY) || w_last_bit);
    assign w_reading    = (r_state == ST_DATA) && r_dir;
    assign w_rx_next    = w_quad ? {r_rx[3:0], io_i} : {r_rx[6:0], io_i[1]};
    assign w_nxt_byte   = r_byte_cnt[4:0] + 5'd1;
    assign w_dummy_quad = ((r_amode == MODE_QUAD) && (r_abytes != 3'd0)) ||
                          ((r_dmode == MODE_QUAD) && (r_dbytes != 6'd0));

    assign w_sclk_en = (r_state == ST_INSTR) || (r_state == ST_ADDR) ||
                       (r_state == ST_DUMMY) || (r_state == ST_DATA);

    qspi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_en     (w_sclk_en),
        .o_sclk   (sclk_o),
        .o_shift  (w_shift),
        .o_sample (w_sample)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_instr    <= '0;
            r_imode    <= '0;
            r_amode    <= '0;
            r_abytes   <= '0;
            r_addr     <= '0;
            r_dummy    <= '0;
            r_dmode    <= '0;
            r_dir      <= 1'b0;
            r_dbytes   <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_shift    <= '0;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_wait_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_instr    <= instr_i;
                        r_imode    <= instr_mode_i;
                        r_amode    <= addr_mode_i;
                        r_abytes   <= w_abytes;
                        r_addr     <= addr_i;
                        r_dummy    <= dummy_i;
                        r_dmode    <= data_mode_i;
                        r_dir      <= data_dir_i;
                        r_dbytes   <= w_dbytes;
                        r_wdata    <= wdata_i;
                        r_rdata    <= '0;
                        r_state    <= w_enter;
                        r_shift    <= w_load_shift;
                        r_rx       <= '0;
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_wait_cnt <= '0;
                    end
                end
                ST_INSTR, ST_ADDR, ST_DUMMY, ST_DATA: begin
                    if (w_sample && w_reading) begin
                        r_rx <= w_rx_next;
                        if (w_last_bit)
                            r_rdata[{r_byte_cnt[4:0], 3'b000} +: 8] <= w_rx_next;
                    end
                    if (w_shift) begin
                        if (w_phase_last) begin
                            r_state    <= w_enter;
                            r_shift    <= w_load_shift;
                            r_rx       <= '0;
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= '0;
                            r_wait_cnt <= '0;
                        end else if (r_state == ST_DUMMY) begin
                            r_byte_cnt <= r_byte_cnt + 6'd1;
                        end else if (w_last_bit) begin
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= r_byte_cnt + 6'd1;
                            // Address bytes are pre-aligned and just keep shifting;
                            // write data is fetched byte by byte from the latched buffer.
                            if (r_state == ST_DATA)
                                r_shift <= {r_wdata[{w_nxt_byte, 3'b000} +: 8], 24'h0};
                            else
                                r_shift <= w_quad ? (r_shift << 4) : (r_shift << 1);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= w_quad ? (r_shift << 4) : (r_shift << 1);
                        end
                    end
                end
                ST_DONE: begin
                    if (r_wait_cnt == DONE_LAST) begin
                        r_state    <= ST_GAP;
                        r_wait_cnt <= '0;
                        r_done     <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_wait_cnt == GAP_LAST)
                        r_state <= ST_IDLE;
                    else
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        io_o    = 4'b0000;
        io_oe_o = 4'b0000;
        case (r_state)
            ST_INSTR, ST_ADDR, ST_DATA: begin
                if (w_reading) begin
                    io_oe_o = w_quad ? 4'b0000 : 4'b1100;
                    io_o    = w_quad ? 4'b0000 : 4'b1100;
                end else if (w_quad) begin
                    io_oe_o = 4'b1111;
                    io_o    = r_shift[31:28];
                end else begin
                    io_oe_o = 4'b1101;
                    io_o    = {3'b110, r_shift[31]};
                end
            end
            ST_DUMMY: begin
                if (!w_dummy_quad) begin
                    io_oe_o = 4'b1100;
                    io_o    = 4'b1100;
                end
            end
            default: begin
                io_o    = 4'b0000;
                io_oe_o = 4'b0000;
            end
        endcase
    end

    assign busy_o  = (r_state != ST_IDLE);
    assign ss_n_o  = ~(w_sclk_en || (r_state == ST_DONE));
    assign done_o  = r_done;
    assign rdata_o = r_rdata;

endmodule
